fetch_stage: RTL

Instruction fetch stage of the pipelined 16-bit processor. It produces the instruction/PC pair consumed by the decode stage and accepts that stage's redirect (flush), stall and halt back-pressure. It owns the PC register, the request/response handshake to instruction memory, a one-entry skid buffer and the IF/ID pipeline register.

---
 rtl/fetch_stage_if.sv | 14 +
 rtl/fetch_stage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage_if : instruction-memory request/response bus.  Rev 1.0
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemReady;
    logic [15:0] imemData;

    modport master (output imemReq, output imemAddr, input imemReady, input imemData);
    modport slave  (input imemReq, input imemAddr, output imemReady, output imemData);
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage : PC, imem handshake, one-entry skid buffer and IF/ID register.
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [15:0]        redirectPC,
    input  logic               haltIn,
    fetch_stage_if.master      imem,
    output logic [15:0]        instr,
    output logic [15:0]        PC,
    output logic               instrValid,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUF    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_req_active;
    logic [15:0] r_req_addr;
    logic        r_drop_pending;
    logic        r_halt_pending;
    logic [15:0] r_buf_instr;
    logic [15:0] r_buf_pc;
    logic [15:0] r_instr;
    logic [15:0] r_pc_out;
    logic        r_valid;
    logic        r_err;

    logic        w_issue;
    logic        w_req;
    logic [15:0] w_addr;
    logic        w_fire;
    logic        w_wait;
    logic        w_halt;
    logic [15:0] w_pc_next;

    // Request is gated by reset so nothing leaks onto the bus while held in reset.
    assign w_issue   = (r_state == ST_RUN) & ~stall & ~r_halt_pending;
    assign w_req     = rst & (r_req_active | w_issue);
    assign w_addr    = r_req_active ? r_req_addr : r_pc;
    assign w_fire    = w_req & imem.imemReady;
    assign w_wait    = w_req & ~imem.imemReady;
    assign w_halt    = r_halt_pending | haltIn;
    assign w_pc_next = w_addr + 16'd2;

    assign imem.imemReq  = w_req;
    assign imem.imemAddr = w_addr;
    assign instr         = r_instr;
    assign PC            = r_pc_out;
    assign instrValid    = r_valid;
    assign err           = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_RUN;
            r_pc           <= RESET_PC;
            r_req_active   <= 1'b0;
            r_req_addr     <= RESET_PC;
            r_drop_pending <= 1'b0;
            r_halt_pending <= 1'b0;
            r_buf_instr    <= NOP_INSTR;
            r_buf_pc       <= RESET_PC;
            r_instr        <= NOP_INSTR;
            r_pc_out       <= RESET_PC;
            r_valid        <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_req_active <= w_wait;
            if (w_wait) begin
                r_req_addr <= w_addr;
            end

            if ((r_state != ST_HALTED) && w_halt) begin
                // Let an outstanding handshake drain (data dropped) before halting.
                r_halt_pending <= 1'b1;
                r_instr        <= NOP_INSTR;
                r_valid        <= 1'b0;
                r_drop_pending <= w_wait;
                if (!w_wait) begin
                    r_state <= ST_HALTED;
                end
            end else if (r_state == ST_HALTED) begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end else if (redirect) begin
                r_pc           <= redirectPC;
                r_instr        <= NOP_INSTR;
                r_valid        <= 1'b0;
                r_buf_instr    <= NOP_INSTR;
                r_buf_pc       <= RESET_PC;
                r_drop_pending <= w_wait;
                r_state        <= ST_RUN;
                if (redirectPC[0]) begin
                    r_err <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_fire) begin
                            if (r_drop_pending) begin
                                r_drop_pending <= 1'b0;
                                if (!stall) begin
                                    r_instr <= NOP_INSTR;
                                    r_valid <= 1'b0;
                                end
                            end else if (!stall) begin
                                r_instr  <= imem.imemData;
                                r_pc_out <= w_pc_next;
                                r_valid  <= 1'b1;
                                r_pc     <= w_pc_next;
                            end else begin
                                r_buf_instr <= imem.imemData;
                                r_buf_pc    <= w_pc_next;
                                r_pc        <= w_pc_next;
                                r_state     <= ST_BUF;
                            end
                        end else if (!stall) begin
                            r_instr <= NOP_INSTR;
                            r_valid <= 1'b0;
                        end
                    end
                    ST_BUF: begin
                        if (!stall) begin
                            r_instr  <= r_buf_instr;
                            r_pc_out <= r_buf_pc;
                            r_valid  <= 1'b1;
                            r_state  <= ST_RUN;
                        end
                    end
                    default: begin
                        r_state <= ST_RUN;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
